// File: rtl/pool_result_collector.sv
// -----------------------------------------------------------------------------
// pool_result_collector
//
// Collects pooled maxima from computation_core and streams them toward the
// feature-map writer. Each rising edge of flag_store samples max_number,
// saturates it from 2*bitwidth to bitwidth signed, and pushes it into a small
// FIFO. The FIFO head is presented on a valid/ready stream. Results are also
// counted per output frame, with a pulse when a frame completes and a sticky
// flag when a result had to be dropped because the FIFO was full.
//
// Optional build macro:
//   RESULT_RELU_EN  - negative saturated results are stored as 0.
//
// Parameters:
//   bitwidth   datapath width (input 2*bitwidth, output bitwidth)
//   DEPTH      FIFO entries, power of two, >= 2
//   FRAME_LEN  results per output frame, >= 2
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset, clears all state
//   max_number  signed pooled result (2*bitwidth)
//   flag_store  result-available flag, one capture per 0->1 transition
//   out_data    signed saturated result at the FIFO head (0 when empty)
//   out_valid   FIFO non-empty
//   out_ready   downstream accepts out_data when out_valid & out_ready
//   full        FIFO holds DEPTH entries
//   frame_done  one-cycle pulse after the FRAME_LEN-th capture of a frame
//   overflow    sticky, a capture arrived while full with no pop
// -----------------------------------------------------------------------------
module pool_result_collector #(
    parameter int bitwidth  = 17,
    parameter int DEPTH     = 8,
    parameter int FRAME_LEN = 196
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [2*bitwidth-1:0] max_number,
    input  logic                         flag_store,
    output logic signed [bitwidth-1:0]   out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         full,
    output logic                         frame_done,
    output logic                         overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = $clog2(FRAME_LEN);

    // Representable range of the narrow result, expressed at input width
    localparam logic signed [2*bitwidth-1:0] SAT_HI =
        {{(bitwidth+1){1'b0}}, {(bitwidth-1){1'b1}}};
    localparam logic signed [2*bitwidth-1:0] SAT_LO =
        {{(bitwidth+1){1'b1}}, {(bitwidth-1){1'b0}}};
    localparam logic signed [bitwidth-1:0] OUT_HI = {1'b0, {(bitwidth-1){1'b1}}};
    localparam logic signed [bitwidth-1:0] OUT_LO = {1'b1, {(bitwidth-1){1'b0}}};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic                       flag_q;
    logic                       armed;
    logic signed [bitwidth-1:0] mem [DEPTH];
    logic [AW-1:0]              wr_ptr;
    logic [AW-1:0]              rd_ptr;
    logic [CW-1:0]              count;
    logic [FW-1:0]              frame_cnt;

    logic                       capture;
    logic                       pop;
    logic                       wr_en;
    logic                       frame_last;
    logic signed [bitwidth-1:0] sat_val;

    // -------------------------------------------------------------------------
    // Capture edge detect
    //
    // flag_q alone resets to 0, so a flag that is already high when reset
    // releases would look like a fresh rising edge on the first clock.
    // 'armed' holds off capture for that first cycle, letting flag_q pick up
    // the real level before any edge is recognised.
    // -------------------------------------------------------------------------
    assign capture = flag_store & ~flag_q & armed;

    // -------------------------------------------------------------------------
    // Saturation (and optional ReLU) of the captured value
    // -------------------------------------------------------------------------
    always_comb begin
        sat_val = max_number[bitwidth-1:0];
        if (max_number > SAT_HI)
            sat_val = OUT_HI;
        else if (max_number < SAT_LO)
            sat_val = OUT_LO;
`ifdef RESULT_RELU_EN
        if (sat_val[bitwidth-1])
            sat_val = '0;
`endif
    end

    // -------------------------------------------------------------------------
    // FIFO control
    //
    // When full, a simultaneous pop frees the head slot in the same edge; the
    // write lands on wr_ptr (== rd_ptr when full), which becomes the tail once
    // rd_ptr advances, so the new value drains last.
    // -------------------------------------------------------------------------
    assign out_valid  = (count != '0);
    assign full       = (count == CW'(DEPTH));
    assign pop        = out_valid & out_ready;
    assign wr_en      = capture & (~full | pop);
    assign frame_last = (frame_cnt == FW'(FRAME_LEN - 1));

    // Head entry straight from the registered array gives first-word-fall-
    // through; gated to 0 when empty so the idle bus is deterministic.
    assign out_data = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_q <= 1'b0;
            armed  <= 1'b0;
        end else begin
            flag_q <= flag_store;
            armed  <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= sat_val;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Overflow: sticky. A dropped capture still counts toward the frame, since
    // the frame is defined by what computation_core produced, not by what fit.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            overflow <= 1'b0;
        else if (capture && full && !pop)
            overflow <= 1'b1;
    end

    // -------------------------------------------------------------------------
    // Frame counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= capture & frame_last;
            if (capture)
                frame_cnt <= frame_last ? '0 : frame_cnt + FW'(1);
        end
    end

endmodule

// File: doc/pool_result_collector.md
Name: pool_result_collector

Overview:
- Downstream consumer of computation_core's pooled-result interface (max_number / flag_store).
- Captures each pooled maximum and saturates it from 2*bitwidth to bitwidth signed.
- Buffers results in a small FIFO and presents them on a valid/ready stream toward the feature-map writer.
- Counts results per output frame and flags frame completion and overflow.

Parameters:
- bitwidth, 17, datapath width; input is 2*bitwidth, output is bitwidth.
- DEPTH, 8, FIFO entries (power of two, >=2).
- FRAME_LEN, 196, results per frame (14x14 pooled map).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- max_number  input  2*bitwidth  signed pooled result from computation_core.
- flag_store  input  1  result-available flag from computation_core; a result is captured once per 0->1 transition.
- out_data  output  bitwidth  signed saturated result at FIFO head.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  downstream accepts out_data when out_valid&out_ready.
- full  output  1  FIFO holds DEPTH entries.
- frame_done  output  1  one-cycle pulse when the FRAME_LEN-th result of a frame is captured.
- overflow  output  1  sticky; set when a capture arrives while full.

Behaviour:
- Reset (async assert, sync deassert): out_data=0, out_valid=0, full=0, frame_done=0, overflow=0; FIFO pointers=0; frame counter=0; flag_store history register=0.
- Edge detect: flag_q registers flag_store each cycle; capture event = flag_store & ~flag_q. A level held high for many cycles captures once. flag_store already high when reset deasserts does not capture.
- Capture data: max_number is sampled in the capture-event cycle.
- Saturation: >2^(bitwidth-1)-1 -> 65535; < -2^(bitwidth-1) -> -65536; else truncate to low bitwidth bits. Limits shown for bitwidth=17.
- Write latency: capture in cycle N; entry visible in cycle N+1 (out_valid=1 at N+1 if FIFO was empty).
- Read: pop on out_valid&out_ready; out_data always shows the head entry (registered memory, first-word-fall-through behaviour).
- Simultaneous capture and pop: when not full, both occur and occupancy is unchanged. When full with a pop in the same cycle, the capture is accepted and overflow is not set.
- Full with no pop: capture discarded, overflow<=1 (sticky until reset), frame counter still increments.
- Pointer wrap: modulo DEPTH. Occupancy counter ranges 0..DEPTH; full = (count==DEPTH).
- Frame counter: increments on every capture event. On the event where count==FRAME_LEN-1, frame_done=1 for the next cycle and the counter returns to 0.
- Empty pop (out_ready with out_valid=0): ignored, no state change.
- Reset mid-frame: the counter clears and the FIFO contents are lost. The next capture is frame index 0.

Optional Feature:
- Macro RESULT_RELU_EN.
- Defined: a negative saturated value is stored as 0 (ReLU after pooling). Overflow and frame_done behaviour are unchanged.
- Undefined: signed saturated value is stored unchanged.

Test Plan:
- Reset, then a single flag_store pulse with max_number=12 -> next cycle out_valid=1, out_data=12; pop with out_ready=1 -> out_valid=0 the following cycle.
- flag_store held high 20 cycles with max_number=7 -> exactly one entry captured; occupancy 1.
- Saturation: capture 100000 -> out_data=65535; capture -100000 -> out_data=-65536 (-> 0 with RESULT_RELU_EN); capture -5 -> -5 (-> 0 with RESULT_RELU_EN).
- out_ready=0, 9 captures of values 1..9 with DEPTH=8 -> full=1 after 8th; overflow=1 after 9th; draining yields 1..8 in order.
- Full FIFO; capture and pop in the same cycle -> overflow stays 0, full stays 1, new value appears last on drain.
- 196 captures with out_ready=1 -> frame_done pulses exactly once, one cycle after the 196th capture; the 197th capture does not pulse. Assert reset after 100 captures, then 196 more -> single pulse after 196.
